// File: rtl/data_mem_responder.sv
// Data-memory responder: valid/ready request port, programmable wait states, single-cycle
// response, and RV32I byte/halfword/word load/store sizing over a word-organised RAM.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_error_o
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  localparam logic [3:0] WaitInit = 4'(WAIT_STATES);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        enter_resp;
  logic        mem_we;
  logic        cur_write;
  logic [2:0]  cur_funct3;
  logic [31:0] cur_addr, cur_wdata;
  logic        acc_err;
  logic [AW-1:0] widx;
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;

  assign accept = (state_q == StIdle) && req_valid_i;

  // With zero wait states the access happens on the accept edge, so use the live request.
  always_comb begin
    if (state_q == StIdle) begin
      cur_write  = req_write_i;
      cur_funct3 = req_funct3_i;
      cur_addr   = req_addr_i;
      cur_wdata  = req_wdata_i;
    end else begin
      cur_write  = write_q;
      cur_funct3 = funct3_q;
      cur_addr   = addr_q;
      cur_wdata  = wdata_q;
    end
  end

  always_comb begin
    acc_err = 1'b0;
    if (cur_write) begin
      if (cur_funct3 > 3'd2) acc_err = 1'b1;
    end else if (cur_funct3 == 3'd3 || cur_funct3 == 3'd6 || cur_funct3 == 3'd7) begin
      acc_err = 1'b1;
    end
    if (cur_funct3[1:0] == 2'd1 && cur_addr[0]) acc_err = 1'b1;
    if (cur_funct3[1:0] == 2'd2 && cur_addr[1:0] != 2'd0) acc_err = 1'b1;
    if ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS)) acc_err = 1'b1;
  end

  assign widx    = cur_addr[AW+1:2];
  assign rd_word = mem[widx];
  assign rd_byte = rd_word[{cur_addr[1:0], 3'b000} +: 8];
  assign rd_half = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_val = 32'h0;
    case (cur_funct3)
      3'd0:    load_val = {{24{rd_byte[7]}}, rd_byte};
      3'd1:    load_val = {{16{rd_half[15]}}, rd_half};
      3'd2:    load_val = rd_word;
      3'd4:    load_val = {24'h0, rd_byte};
      3'd5:    load_val = {16'h0, rd_half};
      default: load_val = 32'h0;
    endcase
  end

  always_comb begin
    wr_be   = 4'hF;
    wr_data = cur_wdata;
    case (cur_funct3[1:0])
      2'd0: begin
        wr_be   = 4'b0001 << cur_addr[1:0];
        wr_data = {4{cur_wdata[7:0]}};
      end
      2'd1: begin
        wr_be   = cur_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{cur_wdata[15:0]}};
      end
      default: begin
        wr_be   = 4'hF;
        wr_data = cur_wdata;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // RESP always exits to IDLE, so a RESP next-state marks the entry edge.
  assign enter_resp = (state_d == StResp);
  assign mem_we     = enter_resp && cur_write && !acc_err && rst_n;

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (enter_resp) begin
      err_d   = acc_err;
      rdata_d = (acc_err || cur_write) ? 32'h0 : load_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      write_q  <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        write_q  <= req_write_i;
        funct3_q <= req_funct3_i;
        addr_q   <= req_addr_i;
        wdata_q  <= req_wdata_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[widx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign req_ready_o  = (state_q == StIdle);
  assign resp_valid_o = (state_q == StResp);
  assign resp_rdata_o = rdata_q;
  assign resp_error_o = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (2, 0 and 5 wait states) driven by a
// directed vector table, hand-written corner sequences and random traffic against a byte model.
module tb_data_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_write  [3];
  logic [2:0]  req_funct3 [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic        resp_valid [3];
  logic [31:0] resp_rdata [3];
  logic        resp_error [3];

  int total = 0;
  int bad   = 0;

  logic [7:0] mdl [3][4096];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_responder #(
      .DEPTH_WORDS(1024),
      .WAIT_STATES((g == 0) ? 2 : ((g == 1) ? 0 : 5))
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid_i (req_valid[g]),
      .req_ready_o (req_ready[g]),
      .req_write_i (req_write[g]),
      .req_funct3_i(req_funct3[g]),
      .req_addr_i  (req_addr[g]),
      .req_wdata_i (req_wdata[g]),
      .resp_valid_o(resp_valid[g]),
      .resp_rdata_o(resp_rdata[g]),
      .resp_error_o(resp_error[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ws_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 0 : 5);
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%h exp=%h", name, d, got, exp);
    end
  endtask

  task automatic timeout(input string name, input int d);
    total++;
    bad++;
    $display("FAIL %s dut%0d got=timeout exp=response", name, d);
  endtask

  // Reference: byte-addressed memory, access size from funct3, alignment by modulo.
  function automatic void ref_access(input int d, input bit wr, input bit [2:0] f3,
                                     input bit [31:0] addr, input bit [31:0] wdata,
                                     output logic [31:0] rdata, output logic err);
    int  size;
    bit  legal;
    size  = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
    legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    err   = !legal || (addr % size != 0) || (addr >= 32'd4096);
    rdata = 32'h0;
    if (err) return;
    if (wr) begin
      for (int i = 0; i < size; i++) mdl[d][addr + i] = wdata[8*i +: 8];
    end else begin
      for (int i = 0; i < size; i++) rdata = rdata | (32'(mdl[d][addr + i]) << (8 * i));
      if (f3 < 3'd4 && size < 4 && rdata[8*size-1]) rdata = rdata | ~((32'd1 << (8 * size)) - 1);
    end
  endfunction

  task automatic do_req(input int d, input bit wr, input bit [2:0] f3, input bit [31:0] addr,
                        input bit [31:0] wdata, output logic [31:0] rdata, output logic err);
    int n;
    bit seen;
    rdata = 32'h0;
    err   = 1'b0;
    @(negedge clk);
    req_write[d]  = wr;
    req_funct3[d] = f3;
    req_addr[d]   = addr;
    req_wdata[d]  = wdata;
    req_valid[d]  = 1'b1;
    n = 0;
    while (!req_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[d]) begin
      timeout("ready", d);
      req_valid[d] = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
    n    = 0;
    seen = 1'b0;
    while (n < 50 && !seen) begin
      @(negedge clk);
      n++;
      if (resp_valid[d]) seen = 1'b1;
    end
    if (!seen) begin
      timeout("resp", d);
      return;
    end
    chk("latency", d, 32'(n), 32'(ws_of(d) + 1));
    rdata = resp_rdata[d];
    err   = resp_error[d];
    @(negedge clk);
    chk("pulse_end", d, {31'h0, resp_valid[d]}, 32'h0);
  endtask

  typedef struct {
    bit        wr;
    bit [2:0]  f3;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [31:0] rdata;
    bit        err;
  } vec_t;

  vec_t vecs [17];

  initial begin
    logic [31:0] rd, exp_rd;
    logic        er, exp_er;
    bit          wr;
    bit [2:0]    f3;
    bit [31:0]   addr, wd;

    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      req_valid[d]  = 1'b0;
      req_write[d]  = 1'b0;
      req_funct3[d] = 3'd0;
      req_addr[d]   = 32'h0;
      req_wdata[d]  = 32'h0;
    end

    vecs[0]  = '{1'b1, 3'd2, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 3'd2, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b0, 3'd0, 32'h13,   32'h0,        32'hFFFFFFDE, 1'b0};
    vecs[3]  = '{1'b0, 3'd4, 32'h13,   32'h0,        32'h000000DE, 1'b0};
    vecs[4]  = '{1'b0, 3'd1, 32'h12,   32'h0,        32'hFFFFDEAD, 1'b0};
    vecs[5]  = '{1'b0, 3'd5, 32'h10,   32'h0,        32'h0000BEEF, 1'b0};
    vecs[6]  = '{1'b1, 3'd0, 32'h11,   32'h00000055, 32'h0,        1'b0};
    vecs[7]  = '{1'b0, 3'd2, 32'h10,   32'h0,        32'hDEAD55EF, 1'b0};
    vecs[8]  = '{1'b1, 3'd1, 32'h12,   32'h00001234, 32'h0,        1'b0};
    vecs[9]  = '{1'b0, 3'd2, 32'h10,   32'h0,        32'h123455EF, 1'b0};
    vecs[10] = '{1'b0, 3'd2, 32'h12,   32'h0,        32'h0,        1'b1};
    vecs[11] = '{1'b1, 3'd1, 32'h11,   32'h0000FFFF, 32'h0,        1'b1};
    vecs[12] = '{1'b0, 3'd2, 32'h10,   32'h0,        32'h123455EF, 1'b0};
    vecs[13] = '{1'b0, 3'd2, 32'h1000, 32'h0,        32'h0,        1'b1};
    vecs[14] = '{1'b0, 3'd3, 32'h10,   32'h0,        32'h0,        1'b1};
    vecs[15] = '{1'b1, 3'd4, 32'h10,   32'hFFFFFFFF, 32'h0,        1'b1};
    vecs[16] = '{1'b0, 3'd2, 32'h10,   32'h0,        32'h123455EF, 1'b0};

    #12;
    for (int d = 0; d < 3; d++) begin
      chk("rst_ready", d, {31'h0, req_ready[d]}, 32'h1);
      chk("rst_valid", d, {31'h0, resp_valid[d]}, 32'h0);
      chk("rst_rdata", d, resp_rdata[d], 32'h0);
      chk("rst_error", d, {31'h0, resp_error[d]}, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      do_req(0, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er);
      chk($sformatf("vec%0d_rdata", i), 0, rd, vecs[i].rdata);
      chk($sformatf("vec%0d_error", i), 0, {31'h0, er}, {31'h0, vecs[i].err});
    end

    // Reset while a store waits: the store must not reach RAM.
    do_req(0, 1'b1, 3'd2, 32'h20, 32'h11223344, rd, er);
    @(negedge clk);
    req_write[0]  = 1'b1;
    req_funct3[0] = 3'd2;
    req_addr[0]   = 32'h20;
    req_wdata[0]  = 32'hA5A5A5A5;
    req_valid[0]  = 1'b1;
    chk("pre_accept_ready", 0, {31'h0, req_ready[0]}, 32'h1);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    chk("wait_ready", 0, {31'h0, req_ready[0]}, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 0, {31'h0, req_ready[0]}, 32'h1);
    chk("midrst_valid", 0, {31'h0, resp_valid[0]}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    do_req(0, 1'b0, 3'd2, 32'h20, 32'h0, rd, er);
    chk("midrst_keep", 0, rd, 32'h11223344);
    chk("midrst_err", 0, {31'h0, er}, 32'h0);

    for (int d = 0; d < 3; d++) begin
      for (int w = 0; w < 32; w++) begin
        wd = $urandom();
        ref_access(d, 1'b1, 3'd2, 32'h200 + 32'(4 * w), wd, exp_rd, exp_er);
        do_req(d, 1'b1, 3'd2, 32'h200 + 32'(4 * w), wd, rd, er);
        chk("init_err", d, {31'h0, er}, {31'h0, exp_er});
      end
      for (int k = 0; k < 60; k++) begin
        wr   = 1'($urandom_range(0, 1));
        f3   = 3'($urandom_range(0, 7));
        addr = 32'h200 + 32'($urandom_range(0, 127));
        if ($urandom_range(0, 7) == 0) addr = $urandom() | 32'h0000_1000;
        wd   = $urandom();
        ref_access(d, wr, f3, addr, wd, exp_rd, exp_er);
        do_req(d, wr, f3, addr, wd, rd, er);
        chk("rand_rdata", d, rd, exp_rd);
        chk("rand_error", d, {31'h0, er}, {31'h0, exp_er});
      end
    end

    // Zero wait states with req_valid held high: accept every second cycle.
    ref_access(1, 1'b0, 3'd2, 32'h200, 32'h0, exp_rd, exp_er);
    @(negedge clk);
    req_write[1]  = 1'b0;
    req_funct3[1] = 3'd2;
    req_addr[1]   = 32'h200;
    req_valid[1]  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("b2b_ready", 1, {31'h0, req_ready[1]}, {31'h0, (i % 2 == 0)});
      chk("b2b_valid", 1, {31'h0, resp_valid[1]}, {31'h0, (i % 2 == 1)});
      if (i % 2 == 1) chk("b2b_rdata", 1, resp_rdata[1], exp_rd);
      @(negedge clk);
    end
    req_valid[1] = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
